// File: rtl/klondike_dealer.sv
// Klondike deal engine: fills an ordered deck, Fisher-Yates shuffles it in place with an
// LFSR, then streams one card per valid/ready beat. `DEALER_BYPASS_EN adds a no_shuffle input.
module klondike_dealer #(
  parameter int          NUM_PILES = 7,
  parameter int          NUM_RANKS = 13,
  parameter int          NUM_SUITS = 4,
  parameter int          LFSR_W    = 16,
  parameter logic [31:0] SEED_RST  = 32'hACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
`ifdef DEALER_BYPASS_EN
  input  logic                           no_shuffle,
`endif
  input  logic                           seed_load,
  input  logic [LFSR_W-1:0]              seed_in,
  output logic                           busy,
  output logic                           done,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [6:0]                     out_card,
  output logic [$clog2(NUM_PILES+1)-1:0] out_dest,
  output logic [5:0]                     out_pos,
  output logic                           out_last
);
  localparam int DECK = NUM_SUITS * NUM_RANKS;
  localparam int TAB  = NUM_PILES * (NUM_PILES + 1) / 2;
  localparam int IW   = (DECK > 1) ? $clog2(DECK) : 1;
  localparam int DW   = $clog2(NUM_PILES + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DECK - 1);
  localparam logic [DW-1:0] LAST_PILE = DW'(NUM_PILES - 1);
  localparam logic [DW-1:0] STOCK     = DW'(NUM_PILES);

  // Fibonacci feedback masks (bit n-1 for polynomial term x^n), widths 8..24.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0829;
      13:      lfsr_taps = 32'h0000_100D;
      14:      lfsr_taps = 32'h0000_2015;
      15:      lfsr_taps = 32'h0000_6000;
      17:      lfsr_taps = 32'h0001_2000;
      18:      lfsr_taps = 32'h0002_0400;
      19:      lfsr_taps = 32'h0004_0023;
      20:      lfsr_taps = 32'h0009_0000;
      21:      lfsr_taps = 32'h0014_0000;
      22:      lfsr_taps = 32'h0030_0000;
      23:      lfsr_taps = 32'h0042_0000;
      24:      lfsr_taps = 32'h00E1_0000;
      default: lfsr_taps = 32'h0000_D008;
    endcase
  endfunction

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  typedef enum logic [1:0] {IDLE, FILL, SHUFFLE, DEAL} state_t;
  state_t state, state_nx;

  logic [5:0]        deck [0:DECK-1];
  logic [IW-1:0]     k, i, j, d, mask;
  logic [3:0]        fill_rank;
  logic [1:0]        fill_suit;
  logic [LFSR_W-1:0] lfsr;
  logic [DW-1:0]     row, pile;
  logic [5:0]        stock_pos;
  logic              bypass, accept, xfer, load, in_tab;

  // Smallest all-ones mask covering i, so j draws from [0, 2^ceil(log2(i+1))).
  always_comb begin
    mask = i;
    for (int b = 1; b < IW; b++) mask = mask | (i >> b);
  end

  assign j      = lfsr[IW-1:0] & mask;
  assign accept = (j <= i);
  assign xfer   = out_valid && out_ready;
  assign load   = (state == DEAL) && (!out_valid || (out_ready && !out_last));
  assign in_tab = (32'(d) < 32'(TAB));
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FILL;
      FILL:    if (k == LAST_IDX) state_nx = (bypass || (DECK == 1)) ? DEAL : SHUFFLE;
      SHUFFLE: if (accept && i == IW'(1)) state_nx = DEAL;
      DEAL:    if (xfer && out_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef DEALER_BYPASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         bypass <= 1'b0;
    else if (state == IDLE && start) bypass <= no_shuffle;
  end
`else
  assign bypass = 1'b0;
`endif

  // Deck storage carries no reset; it is always fully rewritten by FILL.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      deck[k] <= {fill_rank, fill_suit};
    end else if (state == SHUFFLE && accept) begin
      deck[i] <= deck[j];
      deck[j] <= deck[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= SEED_RST[LFSR_W-1:0];
      k         <= '0;
      i         <= '0;
      d         <= '0;
      fill_rank <= '0;
      fill_suit <= '0;
      row       <= '0;
      pile      <= '0;
      stock_pos <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_card  <= '0;
      out_dest  <= '0;
      out_pos   <= '0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          k         <= '0;
          fill_rank <= 4'd1;
          fill_suit <= '0;
          if (!start && seed_load)
            lfsr <= (seed_in == '0) ? LFSR_W'(1) : seed_in;
        end
        FILL: begin
          k <= k + 1'b1;
          if (fill_rank == 4'(NUM_RANKS)) begin
            fill_rank <= 4'd1;
            fill_suit <= fill_suit + 1'b1;
          end else begin
            fill_rank <= fill_rank + 1'b1;
          end
          i         <= LAST_IDX;
          d         <= '0;
          row       <= '0;
          pile      <= '0;
          stock_pos <= '0;
        end
        SHUFFLE: begin
          lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
          if (accept) i <= i - 1'b1;
        end
        DEAL: begin
          if (load) begin
            out_valid <= 1'b1;
            out_last  <= (d == LAST_IDX);
            d         <= d + 1'b1;
            if (in_tab) begin
              out_card <= {deck[d], pile == row};
              out_dest <= pile;
              out_pos  <= 6'(row);
              if (pile == LAST_PILE) begin
                row  <= row + 1'b1;
                pile <= row + 1'b1;
              end else begin
                pile <= pile + 1'b1;
              end
            end else begin
              out_card  <= {deck[d], 1'b0};
              out_dest  <= STOCK;
              out_pos   <= stock_pos;
              stock_pos <= stock_pos + 1'b1;
            end
          end else if (xfer) begin
            // Final beat accepted: drop valid and pulse done as the FSM returns to IDLE.
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_card  <= '0;
            out_dest  <= '0;
            out_pos   <= '0;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_klondike_dealer.sv
// Scoreboard bench for klondike_dealer: default 7-pile deck plus a 3-pile / 2x5 instance.
module tb_klondike_dealer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, seed_load, out_ready;
  logic [15:0] seed_in;
  logic        busy, done, out_valid, out_last;
  logic [6:0]  out_card;
  logic [2:0]  out_dest;
  logic [5:0]  out_pos;
`ifdef DEALER_BYPASS_EN
  logic        no_shuffle;
`endif

  logic        s_rst, s_start, s_seed_load, s_out_ready;
  logic [15:0] s_seed_in;
  logic        s_busy, s_done, s_out_valid, s_out_last;
  logic [6:0]  s_out_card;
  logic [1:0]  s_out_dest;
  logic [5:0]  s_out_pos;
`ifdef DEALER_BYPASS_EN
  logic        s_no_shuffle;
`endif

  klondike_dealer dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef DEALER_BYPASS_EN
    .no_shuffle(no_shuffle),
`endif
    .seed_load(seed_load), .seed_in(seed_in), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_card(out_card),
    .out_dest(out_dest), .out_pos(out_pos), .out_last(out_last));

  klondike_dealer #(.NUM_PILES(3), .NUM_RANKS(5), .NUM_SUITS(2)) dut_s (
    .clk(clk), .rst(s_rst), .start(s_start),
`ifdef DEALER_BYPASS_EN
    .no_shuffle(s_no_shuffle),
`endif
    .seed_load(s_seed_load), .seed_in(s_seed_in), .busy(s_busy), .done(s_done),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_card(s_out_card),
    .out_dest(s_out_dest), .out_pos(s_out_pos), .out_last(s_out_last));

  typedef struct {
    int dest; int pos; int up; int last; int card; bit chk_card;
  } beat_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference deal map: tableau rounds first, then stock; card is the unshuffled code.
  function automatic beat_t exp_beat(input int np, input int nd, input int nr, input int b);
    beat_t e;
    int tab, idx;
    tab = np * (np + 1) / 2;
    e.dest = np; e.pos = b - tab; e.up = 0; e.chk_card = 1'b0;
    if (b < tab) begin
      idx = b;
      for (int r = 0; r < np; r++) begin
        if (idx >= 0 && idx < np - r) begin
          e.dest = r + idx; e.pos = r; e.up = (idx == 0) ? 1 : 0;
        end
        idx = idx - (np - r);
      end
    end
    e.last = (b == nd - 1) ? 1 : 0;
    e.card = ((((b % nr) + 1) << 3) | ((b / nr) << 1) | e.up);
    return e;
  endfunction

  beat_t sb_a[$], sb_s[$];
  int    cap_a[$], cap_s[$], ref_q[$];
  int    nbeats_a, nbeats_s, nup_a;
  bit    done_seen_a, done_seen_s;

  initial begin : mon_a
    beat_t e;
    bit stall, exp_done;
    int h_card, h_dest, h_pos, h_last;
    stall = 0; exp_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0; exp_done = 0;
      end else begin
        if (stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_card", out_card, h_card);
          check("hold_dest", out_dest, h_dest);
          check("hold_pos", out_pos, h_pos);
          check("hold_last", out_last, h_last);
        end
        stall  = out_valid && !out_ready;
        h_card = out_card; h_dest = out_dest; h_pos = out_pos; h_last = out_last;
        if (exp_done) begin
          check("done_pulse", done, 1);
          check("busy_at_done", busy, 0);
          check("valid_after_last", out_valid, 0);
          exp_done = 0; done_seen_a = 1;
        end else if (done) begin
          check("stray_done", done, 0);
        end
        if (out_valid && out_ready) begin
          nbeats_a++;
          if (out_card[0]) nup_a++;
          if (sb_a.size() == 0) check("sb_a_underflow", sb_a.size(), 1);
          else begin
            e = sb_a.pop_front();
            check("dest", out_dest, e.dest);
            check("pos", out_pos, e.pos);
            check("face_up", out_card[0], e.up);
            check("last", out_last, e.last);
            if (e.chk_card) check("card", out_card, e.card);
          end
          cap_a.push_back(int'(out_card[6:1]));
          exp_done = out_last;
        end
      end
    end
  end

  initial begin : mon_s
    beat_t e;
    bit exp_done;
    exp_done = 0;
    forever begin
      @(negedge clk);
      if (exp_done) begin
        check("s_done_pulse", s_done, 1);
        check("s_busy_at_done", s_busy, 0);
        exp_done = 0; done_seen_s = 1;
      end
      if (s_out_valid && s_out_ready) begin
        nbeats_s++;
        if (sb_s.size() == 0) check("sb_s_underflow", sb_s.size(), 1);
        else begin
          e = sb_s.pop_front();
          check("s_dest", s_out_dest, e.dest);
          check("s_pos", s_out_pos, e.pos);
          check("s_face_up", s_out_card[0], e.up);
          check("s_last", s_out_last, e.last);
        end
        cap_s.push_back(int'(s_out_card[6:1]));
        exp_done = s_out_last;
      end
    end
  end

  task automatic prep_a(input bit byp);
    beat_t e;
    sb_a.delete(); cap_a.delete();
    nbeats_a = 0; nup_a = 0; done_seen_a = 0;
    for (int b = 0; b < 52; b++) begin
      e = exp_beat(7, 52, 13, b);
      e.chk_card = byp;
      sb_a.push_back(e);
    end
  endtask

  task automatic run_a(input bit do_seed, input logic [15:0] seed, input int drop_at,
                       input int poke_at, input bit byp);
    int cyc, dropped;
    bit poked;
    int cnt[64];
    prep_a(byp);
    dropped = 0; poked = 0;
    if (do_seed) begin
      seed_in = seed; seed_load = 1'b1;
      @(posedge clk); #1;
      seed_load = 1'b0;
    end
`ifdef DEALER_BYPASS_EN
    no_shuffle = byp;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 0;
    while (!done_seen_a && cyc < 5000) begin
      out_ready = !(drop_at >= 0 && nbeats_a >= drop_at && dropped < 5);
      if (!out_ready) dropped++;
      start = (poke_at >= 0 && nbeats_a >= poke_at && !poked);
      seed_load = start;
      if (start) begin poked = 1; seed_in = 16'hBEEF; end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
    if (!done_seen_a) check("deal_timeout", cyc, 0);
    check("beat_count", nbeats_a, 52);
    check("sb_a_left", sb_a.size(), 0);
    check("faceup_count", nup_a, 7);
    check("idle_after_done", busy, 0);
    foreach (cnt[c]) cnt[c] = 0;
    foreach (cap_a[q]) cnt[cap_a[q]]++;
    for (int c = 0; c < 52; c++) check("perm_card", cnt[(((c % 13) + 1) << 2) | (c / 13)], 1);
  endtask

  task automatic cmp_runs(input string tag);
    check({tag, "_len"}, cap_a.size(), ref_q.size());
    for (int b = 0; b < cap_a.size() && b < ref_q.size(); b++) check(tag, cap_a[b], ref_q[b]);
  endtask

  task automatic abort_a(input int when_beat);
    int cyc;
    prep_a(1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (when_beat < 0) begin
      repeat (60) @(posedge clk);
    end else begin
      cyc = 0;
      while (nbeats_a < when_beat && cyc < 2000) begin
        @(posedge clk);
        cyc++;
      end
      if (nbeats_a < when_beat) check("abort_wait_timeout", nbeats_a, when_beat);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_a.delete();
  endtask

  task automatic run_s();
    beat_t e;
    int cyc;
    int cnt[64];
    sb_s.delete(); cap_s.delete(); nbeats_s = 0; done_seen_s = 0;
    for (int b = 0; b < 10; b++) begin
      e = exp_beat(3, 10, 5, b);
      sb_s.push_back(e);
    end
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    cyc = 0;
    while (!done_seen_s && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done_seen_s) check("s_deal_timeout", cyc, 0);
    check("s_beat_count", nbeats_s, 10);
    check("sb_s_left", sb_s.size(), 0);
    foreach (cnt[c]) cnt[c] = 0;
    foreach (cap_s[q]) cnt[cap_s[q]]++;
    for (int c = 0; c < 10; c++) check("s_perm_card", cnt[(((c % 5) + 1) << 2) | (c / 5)], 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed_in = '0; out_ready = 1'b1;
    s_rst = 1'b1; s_start = 1'b0; s_seed_load = 1'b0; s_seed_in = '0; s_out_ready = 1'b1;
`ifdef DEALER_BYPASS_EN
    no_shuffle = 1'b0; s_no_shuffle = 1'b0;
`endif
    nbeats_a = 0; nbeats_s = 0; nup_a = 0; done_seen_a = 0; done_seen_s = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_card", out_card, 0);
    check("rst_dest", out_dest, 0);
    check("rst_pos", out_pos, 0);
    check("rst_last", out_last, 0);
    rst = 1'b0; s_rst = 1'b0;
    @(posedge clk); #1;

    run_a(1'b1, 16'h1234, -1, -1, 1'b0);
    ref_q = cap_a;
    run_a(1'b1, 16'h1234, -1, -1, 1'b0);
    cmp_runs("repeat_1234");
    run_a(1'b1, 16'h1234, 20, -1, 1'b0);
    cmp_runs("backpressure_1234");

    abort_a(-1);
    abort_a(10);
    run_a(1'b1, 16'h1234, -1, -1, 1'b0);
    cmp_runs("after_abort_1234");

    run_a(1'b1, 16'h0000, -1, -1, 1'b0);
    ref_q = cap_a;
    run_a(1'b1, 16'h0001, -1, 15, 1'b0);
    cmp_runs("seed0_vs_seed1");

`ifdef DEALER_BYPASS_EN
    run_a(1'b0, 16'h0000, -1, -1, 1'b1);
`endif

    run_s();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/klondike_dealer.md
Name: klondike_dealer

Overview:
- Parametrised successor to the fixed 7-pile setup block.
- Builds an ordered deck of NUM_SUITS x NUM_RANKS cards, shuffles it in place (Fisher-Yates driven by an LFSR), then streams the deal as one card per valid/ready handshake.
- Deal order: tableau piles first, in Klondike row order, then the remaining cards to the stock.
- Sits between game reset/start control and the pile-storage blocks. Downstream writes each beat to pile out_dest at slot out_pos.

Parameters:
- NUM_PILES, 7, tableau pile count; requires NUM_PILES*(NUM_PILES+1)/2 <= DECK.
- NUM_RANKS, 13, ranks per suit (1..15).
- NUM_SUITS, 4, suit count (1..4).
- LFSR_W, 16, shuffle LFSR width (maximal-length taps, >= 8).
- SEED_RST, 16'hACE1, LFSR value after reset (truncated to LFSR_W).
- Derived localparams: DECK=NUM_SUITS*NUM_RANKS, TAB=NUM_PILES*(NUM_PILES+1)/2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin build/shuffle/deal; sampled in IDLE only
- seed_load  in  1  load seed_in into LFSR; IDLE only
- seed_in  in  LFSR_W  seed value
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the final card handshake
- out_valid  out  1  card beat valid
- out_ready  in  1  downstream accepts the beat
- out_card  out  7  card code: [6:3] rank, [2:1] suit, [0] face-up
- out_dest  out  clog2(NUM_PILES+1)  0..NUM_PILES-1 = tableau pile; NUM_PILES = stock
- out_pos  out  6  slot index within the destination pile
- out_last  out  1  high on the final (DECK-th) beat

Behaviour:
- Reset: all outputs 0; state IDLE; LFSR=SEED_RST; deck RAM contents don't-care.
- Seed load: seed_load in IDLE loads LFSR=seed_in. A zero seed is replaced by 1 (avoids lock-up). seed_load is ignored outside IDLE; start has priority if both are high.
- IDLE -> FILL on start. start is ignored while busy.
- FILL (DECK cycles):
  - Index k=0..DECK-1.
  - deck[k] = {rank=(k mod NUM_RANKS)+1, suit=k/NUM_RANKS, up=0}.
- SHUFFLE:
  - i runs from DECK-1 down to 1. The LFSR advances every SHUFFLE cycle.
  - j = LFSR & mask, where mask = 2^ceil(log2(i+1))-1.
  - If j>i: reject and retry next cycle.
  - Else: swap deck[i] and deck[j] in the same cycle, then decrement i.
  - Exit to DEAL when i reaches 0.
- DEAL:
  - Read pointer d=0..DECK-1 consumes the deck in order.
  - Tableau phase: for round r=0..NUM_PILES-1, pile p=r..NUM_PILES-1 emits dest=p, pos=r, face-up bit = (p==r).
  - Stock phase: after TAB beats, dest=NUM_PILES, pos=0,1,..., face-up=0.
  - out_last=1 when d==DECK-1.
- Handshake:
  - out_valid rises the cycle after entering DEAL.
  - A transfer occurs when out_valid && out_ready.
  - out_card, out_dest, out_pos and out_last are held stable while out_valid && !out_ready.
  - out_valid is never withdrawn without a transfer.
  - Next beat is presented the cycle after a transfer (throughput: 1 per cycle when ready is held high).
- Completion: after the last transfer, out_valid=0 and done=1 for exactly one cycle; state returns to IDLE (busy=0 in the same cycle as done).
- Reset mid-operation: immediate return to IDLE. No partial beat survives; the downstream must treat rst as a deal abort.
- Output is always a permutation: each of the DECK codes appears exactly once with up masked.

Optional Feature:
- Macro DEALER_BYPASS_EN.
- Defined: adds input no_shuffle (1 bit), sampled with start. If no_shuffle=1, FILL goes directly to DEAL (unshuffled, deterministic order) and the LFSR does not advance.
- Undefined: no port; SHUFFLE is always executed.

Test Plan:
- Bypass deal, defaults, out_ready=1:
  - beat0 = 7'h09 dest0 pos0.
  - beat1 = 7'h10 dest1 pos0.
  - beat7 = 7'h41 dest1 pos1.
  - beat28 = 7'h1C dest7 pos0.
  - beat51 = 7'h6E dest7 pos23 out_last=1.
  - done pulses 1 cycle later.
- Shuffle, seed_in=16'h1234, run twice: both runs produce identical 52-beat sequences. All 52 {rank,suit} codes appear exactly once. Exactly 7 face-up beats, at beats 0,7,13,18,22,25,27.
- Backpressure: drop out_ready for 5 cycles mid-deal -> out_valid stays 1 and the data stays stable. The total beat count remains 52 with no duplicates.
- rst asserted during SHUFFLE and during DEAL beat 10 -> the next cycle shows busy=0, out_valid=0, done=0. A following start completes normally.
- seed_load with seed_in=0 -> the run completes, i.e. it does not hang, and the sequence equals that of seed 1. start asserted while busy has no effect.
- NUM_PILES=3, NUM_SUITS=2, NUM_RANKS=5 -> 10 beats: 6 tableau beats (dests 0,1,2,1,2,2), then 4 stock beats with pos 0..3.
